mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Shares the single unified memory port between the core's instruction-fetch path and its load/store path, so the processor can run from one single-ported memory instead of separate instruction and data memories. It sits between the datapath (fetch address, `rd_en`/`wr_en`/`rd_mask` load/store requests) and the memory interface. It serialises requests with a round-robin FSM, formats load data and store byte-lanes, and drives a stall that holds the PC until the current instruction's accesses complete.

## Interface
- ADDR_W, 32, address width of both requesters and memory
- DATA_W, 32, data width (fixed 32; byte-lane logic assumes 4 lanes)

- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- if_req  in  1  fetch request, level, held until if_gnt
- if_addr  in  ADDR_W  fetch address, stable while if_req
- if_rdata  out  32  fetched instruction, valid when if_gnt
- if_gnt  out  1  one-cycle fetch completion pulse
- d_rd_en  in  1  load request, level, held until d_done
- d_wr_en  in  1  store request, level, held until d_done
- d_addr  in  ADDR_W  byte address, stable while request high
- d_wdata  in  32  store data (LSB-aligned)
- d_mask  in  3  funct3 size code: 000 B, 001 H, 010 W, 100 BU, 101 HU
- d_rdata  out  32  extended load data, valid when d_done
- d_done  out  1  one-cycle load/store completion pulse
- d_err  out  1  misaligned access, pulses with d_done
- stall  out  1  hold PC / register writeback
- mem_req  out  1  memory request, held until mem_ack
- mem_we  out  1  write strobe
- mem_addr  out  ADDR_W  word address (bits [1:0] forced 0)
- mem_wdata  out  32  lane-replicated store data
- mem_be  out  4  byte enables
- mem_ack  in  1  memory completion pulse; mem_rdata valid same cycle
- mem_rdata  in  32  memory read data

## Operation
- FSM states: IDLE, BUSY_IF, BUSY_D, RESP.
- IDLE:
  - Only fetch pending: go to BUSY_IF.
  - Only data pending: go to BUSY_D.
  - Both pending: grant the side opposite `last_gnt`.
  - Record the granted side in `last_gnt`.
  - `last_gnt` resets to data, so fetch wins the first tie.
- Misaligned data requests go IDLE→RESP directly with no memory access.
  - Misaligned means: H/HU with addr[0]=1, or W with addr[1:0]≠0.
  - The RESP cycle pulses d_done and d_err. d_rdata = 0.
- BUSY_x:
  - mem_req=1. mem_addr, mem_we, mem_wdata, mem_be come from the registered grant and are stable until mem_ack.
  - On mem_ack, mem_rdata is captured (extended for loads) and the FSM goes to RESP.
- RESP: one-cycle pulse of if_gnt or d_done for the granted side, then IDLE.
  - The granted requester must drop its request the cycle after the pulse.
  - The arbiter ignores that requester's request during RESP.
- d_rd_en and d_wr_en both high: treated as a store; d_rdata = 0.
- Store lanes:
  - B: wdata[7:0] replicated ×4, be = 0001 << addr[1:0].
  - H: wdata[15:0] replicated ×2, be = 0011 << addr[1:0].
  - W: be = 1111.
- Loads: mem_be = 1111, mem_we = 0.
  - Select the byte or half at addr[1:0].
  - B/H sign-extend; BU/HU zero-extend; W passes through.
- Fetch: mem_we = 0, mem_be = 1111; if_rdata = mem_rdata unmodified.
- stall = (if_req | d_rd_en | d_wr_en) & ~(if_gnt | d_done). Combinational.
- mem_ack outside BUSY_x is ignored.

## Timing
- Reset (asynchronous, immediate):
  - State IDLE, last_gnt = data.
  - Outputs mem_req, mem_we, if_gnt, d_done, d_err = 0.
  - if_rdata, d_rdata, mem_addr, mem_wdata, mem_be = 0.
- Reset mid-transaction:
  - mem_req drops asynchronously and the access is abandoned.
  - A late mem_ack is ignored.
  - Requesters re-issue after reset releases.
- Latency, request seen in IDLE at cycle 0:
  - mem_req high from cycle 1.
  - mem_ack at cycle 1+k; completion pulse at cycle 2+k.
  - Zero-wait memory gives 3 cycles from request to next IDLE.
- Misaligned: d_done/d_err at cycle 1.
- Back-to-back: after RESP, a pending other-side request is granted in the following IDLE cycle.
- Worst case for a load/store instruction: fetch plus data (6 cycles at zero wait), with stall held throughout.

## Test plan
- Fetch only, addr 0x0000_0010, mem_ack same cycle as mem_req with rdata 0x0050_0093:
  - mem_req at cycle 1; if_gnt at cycle 2 with if_rdata = 0x0050_0093.
  - stall high cycles 0–1, low at cycle 2.
- LB at 0x103, mem_rdata 0x80FF_0000: d_rdata = 0xFFFF_FF80.
  - Repeat with LBU: d_rdata = 0x0000_0080.
  - LHU at 0x102 with the same data: d_rdata = 0x0000_80FF.
- SH at 0x202, wdata 0x1234_ABCD:
  - mem_addr = 0x200, mem_be = 1100, mem_wdata = 0xABCD_ABCD, mem_we = 1.
- Simultaneous if_req and d_rd_en after reset:
  - Fetch granted first, data second.
  - Repeat while both stay pending: grants alternate.
- LW at 0x301:
  - No mem_req.
  - d_done and d_err pulse at cycle 1; d_rdata = 0.
- Reset asserted with mem_req high and mem_ack 2 cycles late:
  - mem_req is 0 immediately.
  - The late ack produces no if_gnt or d_done pulse.

Source files
------------

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch and
// load/store. Formats store byte lanes, extends load data, flags misaligned
// data accesses without touching memory, and stalls the PC until the
// pending accesses complete.
module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_gnt,
    input  logic              d_rd_en,
    input  logic              d_wr_en,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic [2:0]        d_mask,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_done,
    output logic              d_err,
    output logic              stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [3:0]        mem_be,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_D, RESP} state_t;

    state_t            state_reg, state_next;
    logic              last_gnt_reg;   // 1 = data side was granted last
    logic              side_d_reg;     // side currently being served
    logic              err_reg;
    logic              we_reg;
    logic [1:0]        size_reg;       // 00 byte, 01 half, 1x word
    logic              unsigned_reg;
    logic [1:0]        addr_lo_reg;
    logic [ADDR_W-1:0] mem_addr_reg;
    logic [DATA_W-1:0] mem_wdata_reg;
    logic [3:0]        mem_be_reg;
    logic [DATA_W-1:0] if_rdata_reg;
    logic [DATA_W-1:0] d_rdata_reg;

    logic              d_pend;
    logic              pick_d;
    logic              is_byte, is_half, is_word;
    logic              misaligned;
    logic [DATA_W-1:0] store_wdata;
    logic [3:0]        store_be;
    logic [7:0]        lane [4];
    logic [7:0]        load_byte;
    logic [15:0]       load_half;
    logic [DATA_W-1:0] load_data;

    // Byte lanes of the returning memory word, indexed by address low bits
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign lane[gi] = mem_rdata[8*gi +: 8];
        end
    endgenerate

    // Request decode, round-robin choice, misalignment and store lane formatting
    always_comb begin
        d_pend     = d_rd_en | d_wr_en;
        pick_d     = d_pend & (~if_req | ~last_gnt_reg);
        is_byte    = (d_mask[1:0] == 2'b00);
        is_half    = (d_mask[1:0] == 2'b01);
        is_word    = d_mask[1];
        misaligned = (is_half & d_addr[0]) | (is_word & (d_addr[1:0] != 2'b00));
        store_wdata = d_wdata;
        store_be    = 4'b1111;
        if (is_byte) begin
            store_wdata = {4{d_wdata[7:0]}};
            store_be    = 4'b0001 << d_addr[1:0];
        end else if (is_half) begin
            store_wdata = {2{d_wdata[15:0]}};
            store_be    = 4'b0011 << d_addr[1:0];
        end
    end

    // Load data selection and sign/zero extension from the registered grant
    always_comb begin
        load_byte = lane[addr_lo_reg];
        load_half = addr_lo_reg[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        load_data = mem_rdata;
        case (size_reg)
            2'b00:   load_data = unsigned_reg ? {24'h0, load_byte}
                                              : {{24{load_byte[7]}}, load_byte};
            2'b01:   load_data = unsigned_reg ? {16'h0, load_half}
                                              : {{16{load_half[15]}}, load_half};
            default: load_data = mem_rdata;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; misaligned data requests skip the memory entirely
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (pick_d) begin
                    state_next = misaligned ? RESP : BUSY_D;
                end else if (if_req) begin
                    state_next = BUSY_IF;
                end
            end
            BUSY_IF, BUSY_D: begin
                if (mem_ack) begin
                    state_next = RESP;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Grant bookkeeping, memory command registers and response capture
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_gnt_reg  <= 1'b1;
            side_d_reg    <= 1'b0;
            err_reg       <= 1'b0;
            we_reg        <= 1'b0;
            size_reg      <= 2'b10;
            unsigned_reg  <= 1'b0;
            addr_lo_reg   <= 2'b00;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
            mem_be_reg    <= 4'b0000;
            if_rdata_reg  <= '0;
            d_rdata_reg   <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (pick_d) begin
                        side_d_reg    <= 1'b1;
                        last_gnt_reg  <= 1'b1;
                        err_reg       <= misaligned;
                        we_reg        <= d_wr_en;
                        size_reg      <= d_mask[1:0];
                        unsigned_reg  <= d_mask[2];
                        addr_lo_reg   <= d_addr[1:0];
                        mem_addr_reg  <= d_addr & ~ADDR_W'(3);
                        mem_wdata_reg <= d_wr_en ? store_wdata : '0;
                        mem_be_reg    <= d_wr_en ? store_be : 4'b1111;
                        if (misaligned) begin
                            d_rdata_reg <= '0;
                        end
                    end else if (if_req) begin
                        side_d_reg    <= 1'b0;
                        last_gnt_reg  <= 1'b0;
                        err_reg       <= 1'b0;
                        we_reg        <= 1'b0;
                        mem_addr_reg  <= if_addr & ~ADDR_W'(3);
                        mem_wdata_reg <= '0;
                        mem_be_reg    <= 4'b1111;
                    end
                end
                BUSY_IF: begin
                    if (mem_ack) begin
                        if_rdata_reg <= mem_rdata;
                    end
                end
                BUSY_D: begin
                    if (mem_ack) begin
                        d_rdata_reg <= we_reg ? '0 : load_data;
                    end
                end
                default: ;
            endcase
        end
    end

    assign mem_req   = (state_reg == BUSY_IF) || (state_reg == BUSY_D);
    assign mem_we    = we_reg & mem_req;
    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;
    assign mem_be    = mem_be_reg;
    assign if_gnt    = (state_reg == RESP) & ~side_d_reg;
    assign d_done    = (state_reg == RESP) & side_d_reg;
    assign d_err     = d_done & err_reg;
    assign if_rdata  = if_rdata_reg;
    assign d_rdata   = d_rdata_reg;
    assign stall     = (if_req | d_rd_en | d_wr_en) & ~(if_gnt | d_done);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: fetch, loads with extension, stores with
// byte lanes, misaligned access, round-robin alternation and mid-access reset.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic [31:0] if_rdata;
    logic        if_gnt;
    logic        d_rd_en = 1'b0;
    logic        d_wr_en = 1'b0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic [2:0]  d_mask = 3'b010;
    logic [31:0] d_rdata;
    logic        d_done;
    logic        d_err;
    logic        stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;

    int checks = 0;
    int errors = 0;

    // memory responder controls
    logic auto_ack = 1'b1;
    int   ack_wait = 0;
    int   wait_cnt = 0;

    // captured results of the last data transaction
    logic        saw_req;
    logic        cap_we;
    logic [31:0] cap_addr, cap_wdata;
    logic [3:0]  cap_be;
    logic [31:0] got_rdata;
    logic        got_err;
    int          done_cycle;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_gnt(if_gnt),
        .d_rd_en(d_rd_en), .d_wr_en(d_wr_en), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_mask(d_mask), .d_rdata(d_rdata), .d_done(d_done), .d_err(d_err),
        .stall(stall), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory model: acks after ack_wait cycles of mem_req, one cycle wide
    always @(negedge clk) begin
        if (auto_ack) begin
            if (mem_req && !mem_ack) begin
                if (wait_cnt >= ack_wait) begin
                    mem_ack = 1'b1;
                    wait_cnt = 0;
                end else begin
                    wait_cnt = wait_cnt + 1;
                end
            end else begin
                mem_ack = 1'b0;
            end
        end
    end

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Issue one data request at mid-cycle 0 and follow it to d_done
    task automatic run_data(input logic rd, input logic wr, input logic [2:0] mask,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [31:0] mdata);
        d_rd_en = rd; d_wr_en = wr; d_mask = mask; d_addr = addr; d_wdata = wdata;
        mem_rdata = mdata;
        saw_req = 1'b0; cap_we = 1'b0; cap_addr = '0; cap_wdata = '0; cap_be = '0;
        got_rdata = '0; got_err = 1'b0; done_cycle = -1;
        for (int c = 1; c <= 20 && done_cycle < 0; c++) begin
            @(negedge clk); #1;
            if (mem_req && !saw_req) begin
                saw_req = 1'b1; cap_we = mem_we; cap_addr = mem_addr;
                cap_wdata = mem_wdata; cap_be = mem_be;
            end
            if (d_done) begin
                done_cycle = c; got_rdata = d_rdata; got_err = d_err;
            end
        end
        d_rd_en = 1'b0; d_wr_en = 1'b0;
        if (done_cycle < 0) check_value("d_done_timeout", 32'd0, 32'd1);
        $display("txn data rd=%0b wr=%0b mask=%03b addr=0x%08h -> rdata=0x%08h err=%0b cycle=%0d",
                 rd, wr, mask, addr, got_rdata, got_err, done_cycle);
        @(negedge clk); #1;
    endtask

    initial begin
        int pulse_cycle [4];
        int pulse_side [4];
        int npulse;

        // ---------------- reset state ----------------
        repeat (2) @(negedge clk);
        #1;
        check_value("rst_mem_req", 32'(mem_req), 32'd0);
        check_value("rst_mem_we", 32'(mem_we), 32'd0);
        check_value("rst_if_gnt", 32'(if_gnt), 32'd0);
        check_value("rst_d_done", 32'(d_done), 32'd0);
        check_value("rst_d_err", 32'(d_err), 32'd0);
        check_value("rst_if_rdata", if_rdata, 32'd0);
        check_value("rst_d_rdata", d_rdata, 32'd0);
        check_value("rst_mem_addr", mem_addr, 32'd0);
        check_value("rst_mem_wdata", mem_wdata, 32'd0);
        check_value("rst_mem_be", 32'(mem_be), 32'd0);
        check_value("rst_stall", 32'(stall), 32'd0);
        @(negedge clk); reset = 1'b1;
        @(negedge clk); #1;

        // ---------------- fetch, zero wait ----------------
        if_req = 1'b1; if_addr = 32'h0000_0010; mem_rdata = 32'h0050_0093;
        #1;
        check_value("f_c0_stall", 32'(stall), 32'd1);
        check_value("f_c0_mem_req", 32'(mem_req), 32'd0);
        @(negedge clk); #1;
        check_value("f_c1_mem_req", 32'(mem_req), 32'd1);
        check_value("f_c1_mem_addr", mem_addr, 32'h0000_0010);
        check_value("f_c1_mem_be", 32'(mem_be), 32'hF);
        check_value("f_c1_mem_we", 32'(mem_we), 32'd0);
        check_value("f_c1_stall", 32'(stall), 32'd1);
        check_value("f_c1_if_gnt", 32'(if_gnt), 32'd0);
        @(negedge clk); #1;
        check_value("f_c2_if_gnt", 32'(if_gnt), 32'd1);
        check_value("f_c2_if_rdata", if_rdata, 32'h0050_0093);
        check_value("f_c2_stall", 32'(stall), 32'd0);
        $display("txn fetch addr=0x%08h -> rdata=0x%08h", if_addr, if_rdata);
        if_req = 1'b0;
        @(negedge clk); #1;
        check_value("f_c3_if_gnt", 32'(if_gnt), 32'd0);

        // ---------------- loads ----------------
        ack_wait = 2;
        run_data(1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'h0, 32'h80FF_0000);
        check_value("lb_rdata", got_rdata, 32'hFFFF_FF80);
        check_value("lb_cycle", 32'(done_cycle), 32'd4);
        check_value("lb_mem_be", 32'(cap_be), 32'hF);
        check_value("lb_mem_addr", cap_addr, 32'h0000_0100);
        ack_wait = 0;
        run_data(1'b1, 1'b0, 3'b100, 32'h0000_0103, 32'h0, 32'h80FF_0000);
        check_value("lbu_rdata", got_rdata, 32'h0000_0080);
        check_value("lbu_cycle", 32'(done_cycle), 32'd2);
        run_data(1'b1, 1'b0, 3'b101, 32'h0000_0102, 32'h0, 32'h80FF_0000);
        check_value("lhu_rdata", got_rdata, 32'h0000_80FF);
        run_data(1'b1, 1'b0, 3'b001, 32'h0000_0100, 32'h0, 32'h1234_8001);
        check_value("lh_rdata", got_rdata, 32'hFFFF_8001);
        run_data(1'b1, 1'b0, 3'b010, 32'h0000_0104, 32'h0, 32'hDEAD_BEEF);
        check_value("lw_rdata", got_rdata, 32'hDEAD_BEEF);
        check_value("lw_err", 32'(got_err), 32'd0);

        // ---------------- stores ----------------
        run_data(1'b0, 1'b1, 3'b001, 32'h0000_0202, 32'h1234_ABCD, 32'h0);
        check_value("sh_mem_addr", cap_addr, 32'h0000_0200);
        check_value("sh_mem_be", 32'(cap_be), 32'b1100);
        check_value("sh_mem_wdata", cap_wdata, 32'hABCD_ABCD);
        check_value("sh_mem_we", 32'(cap_we), 32'd1);
        run_data(1'b0, 1'b1, 3'b000, 32'h0000_0101, 32'h0000_0055, 32'h0);
        check_value("sb_mem_be", 32'(cap_be), 32'b0010);
        check_value("sb_mem_wdata", cap_wdata, 32'h5555_5555);
        run_data(1'b1, 1'b1, 3'b010, 32'h0000_0300, 32'h0BAD_F00D, 32'hFFFF_FFFF);
        check_value("rdwr_mem_we", 32'(cap_we), 32'd1);
        check_value("rdwr_mem_be", 32'(cap_be), 32'hF);
        check_value("rdwr_mem_wdata", cap_wdata, 32'h0BAD_F00D);
        check_value("rdwr_rdata", got_rdata, 32'd0);

        // ---------------- misaligned LW ----------------
        run_data(1'b1, 1'b0, 3'b010, 32'h0000_0301, 32'h0, 32'h1111_1111);
        check_value("mis_no_req", 32'(saw_req), 32'd0);
        check_value("mis_cycle", 32'(done_cycle), 32'd1);
        check_value("mis_err", 32'(got_err), 32'd1);
        check_value("mis_rdata", got_rdata, 32'd0);

        // ---------------- round robin after reset ----------------
        reset = 1'b0;
        @(negedge clk); reset = 1'b1;
        @(negedge clk); #1;
        if_req = 1'b1; if_addr = 32'h0000_0040;
        d_rd_en = 1'b1; d_mask = 3'b010; d_addr = 32'h0000_0400;
        mem_rdata = 32'hCAFE_0001;
        npulse = 0;
        for (int c = 1; c <= 30 && npulse < 4; c++) begin
            @(negedge clk); #1;
            if (if_gnt || d_done) begin
                pulse_cycle[npulse] = c;
                pulse_side[npulse] = d_done ? 1 : 0;
                $display("txn rr grant %0d side=%s cycle=%0d", npulse,
                         d_done ? "data" : "fetch", c);
                npulse = npulse + 1;
            end
        end
        if_req = 1'b0; d_rd_en = 1'b0;
        check_value("rr_count", 32'(npulse), 32'd4);
        for (int i = 0; i < npulse; i++) begin
            check_value($sformatf("rr_side%0d", i), 32'(pulse_side[i]), 32'(i % 2));
            check_value($sformatf("rr_cycle%0d", i), 32'(pulse_cycle[i]), 32'(2 + 3 * i));
        end
        @(negedge clk); #1;

        // ---------------- reset mid-access, late ack ----------------
        auto_ack = 1'b0; mem_ack = 1'b0;
        if_req = 1'b1; if_addr = 32'h0000_0020;
        @(negedge clk); #1;
        check_value("rm_mem_req_before", 32'(mem_req), 32'd1);
        reset = 1'b0;
        #1;
        check_value("rm_mem_req_async", 32'(mem_req), 32'd0);
        check_value("rm_mem_addr", mem_addr, 32'd0);
        if_req = 1'b0;
        @(negedge clk); reset = 1'b1;
        @(negedge clk); mem_ack = 1'b1;
        @(negedge clk); mem_ack = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            check_value("rm_no_if_gnt", 32'(if_gnt), 32'd0);
            check_value("rm_no_d_done", 32'(d_done), 32'd0);
            check_value("rm_no_mem_req", 32'(mem_req), 32'd0);
            @(negedge clk);
        end
        // re-issued fetch completes normally
        auto_ack = 1'b1; wait_cnt = 0; mem_rdata = 32'h0000_0013;
        #1;
        if_req = 1'b1;
        done_cycle = -1;
        for (int c = 1; c <= 20 && done_cycle < 0; c++) begin
            @(negedge clk); #1;
            if (if_gnt) done_cycle = c;
        end
        if_req = 1'b0;
        $display("txn fetch reissue -> rdata=0x%08h cycle=%0d", if_rdata, done_cycle);
        check_value("rm_reissue_cycle", 32'(done_cycle), 32'd2);
        check_value("rm_reissue_rdata", if_rdata, 32'h0000_0013);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
